asic_output_analyzer: RTL

Downstream consumer of the XADC measurement path. It takes the four 12-bit auxiliary-channel samples (MEASURED_AUX0..3) produced by `xadc_interface`, with a per-sample valid strobe, and averages each channel over a power-of-two window. It then selects the winning neuromorphic ASIC output channel with a 4-cycle sequential comparator. The resulting `network_output` class, winner magnitude and status flags feed `axi_cfg_regs` and the LED/PWM character logic.

---
 rtl/asic_output_analyzer_if.sv | 28 ++
 rtl/asic_output_analyzer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/asic_output_analyzer_if.sv
// Sample/result bus between the XADC front end and the output analyzer.
// master drives samples and controls; slave is the analyzer.
interface asic_output_analyzer_if #(
  parameter int SAMPLE_WIDTH = 12
);
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] aux0;
  logic [SAMPLE_WIDTH-1:0] aux1;
  logic [SAMPLE_WIDTH-1:0] aux2;
  logic [SAMPLE_WIDTH-1:0] aux3;
  logic [SAMPLE_WIDTH-1:0] threshold;
  logic                    clear;
  logic [1:0]              network_output;
  logic [SAMPLE_WIDTH-1:0] winner_avg;
  logic                    no_winner;
  logic                    result_valid;
  logic                    sample_overrun;

  modport master (
    output sample_valid, aux0, aux1, aux2, aux3, threshold, clear,
    input  network_output, winner_avg, no_winner, result_valid, sample_overrun
  );

  modport slave (
    input  sample_valid, aux0, aux1, aux2, aux3, threshold, clear,
    output network_output, winner_avg, no_winner, result_valid, sample_overrun
  );
endinterface

// File: rtl/asic_output_analyzer.sv
// Windowed per-channel averaging of four AUX samples followed by a 4-step argmax.
// Optional macro ANALYZER_HYST_EN adds hysteresis to winner changes.
module asic_output_analyzer #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int WINDOW_LOG2  = 4,
  parameter int HYST         = 32
) (
  input logic                   clk,
  input logic                   rst,
  asic_output_analyzer_if.slave bus
);
  localparam int AW = SAMPLE_WIDTH + WINDOW_LOG2;
  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << WINDOW_LOG2) - 1);

  localparam logic [2:0] ACCUM  = 3'd0;
  localparam logic [2:0] REPORT = 3'd1;
  localparam logic [2:0] CMP0   = 3'd4;
  localparam logic [2:0] CMP1   = 3'd5;
  localparam logic [2:0] CMP2   = 3'd6;
  localparam logic [2:0] CMP3   = 3'd7;

  if (WINDOW_LOG2 < 0 || WINDOW_LOG2 > 8 || HYST < 0) begin : g_param_check
    $error("asic_output_analyzer: WINDOW_LOG2 must be 0..8 and HYST non-negative");
  end

  function automatic logic [SAMPLE_WIDTH-1:0] window_avg(input logic [AW-1:0] a);
    window_avg = SAMPLE_WIDTH'(a >> WINDOW_LOG2);
  endfunction

  logic [SAMPLE_WIDTH-1:0] aux_w  [4];
  logic [AW-1:0]           sum_w  [4];
  logic [AW-1:0]           acc_q  [4];
  logic [AW-1:0]           acc_d  [4];
  logic [SAMPLE_WIDTH-1:0] snap_q [4];
  logic [SAMPLE_WIDTH-1:0] snap_d [4];
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] max_q, max_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              net_q, net_d;
  logic [SAMPLE_WIDTH-1:0] wavg_q, wavg_d;
  logic                    nw_q, nw_d;
  logic                    rv_q, rv_d;
  logic                    ovr_q, ovr_d;

  assign aux_w[0] = bus.aux0;
  assign aux_w[1] = bus.aux1;
  assign aux_w[2] = bus.aux2;
  assign aux_w[3] = bus.aux3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum_w[i] = acc_q[i] + AW'(aux_w[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_d[i]  = acc_q[i];
      snap_d[i] = snap_q[i];
    end
    cnt_d   = cnt_q;
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    net_d   = net_q;
    wavg_d  = wavg_q;
    nw_d    = nw_q;
    rv_d    = 1'b0;
    ovr_d   = ovr_q;

    if (bus.clear) begin
      for (int i = 0; i < 4; i++) begin
        acc_d[i]  = '0;
        snap_d[i] = '0;
      end
      cnt_d   = '0;
      state_d = ACCUM;
      ovr_d   = 1'b0;
    end else begin
      // Comparator: one channel per edge, ties keep the lower index
      case (state_q)
        CMP0: begin
          max_d   = snap_q[0];
          idx_d   = 2'd0;
          state_d = CMP1;
        end
        CMP1, CMP2, CMP3: begin
          if (snap_q[state_q[1:0]] > max_q) begin
            max_d = snap_q[state_q[1:0]];
            idx_d = state_q[1:0];
          end
          state_d = (state_q == CMP3) ? REPORT : state_q + 3'd1;
        end
        REPORT: begin
          rv_d    = 1'b1;
          state_d = ACCUM;
          wavg_d  = max_q;
          if (max_q < bus.threshold) begin
            nw_d = 1'b1;
          end else begin
            nw_d = 1'b0;
`ifdef ANALYZER_HYST_EN
            if (idx_q == net_q || int'(max_q) > int'(snap_q[net_q]) + HYST) begin
              net_d = idx_q;
            end else begin
              wavg_d = snap_q[net_q];
            end
`else
            net_d = idx_q;
`endif
          end
        end
        default: ;
      endcase

      // Accumulation runs in every state so no sample is dropped
      if (bus.sample_valid) begin
        for (int i = 0; i < 4; i++) begin
          acc_d[i] = sum_w[i];
        end
        if (cnt_q == LAST) begin
          cnt_d = '0;
          for (int i = 0; i < 4; i++) begin
            acc_d[i] = '0;
          end
          if (state_q == ACCUM) begin
            for (int i = 0; i < 4; i++) begin
              snap_d[i] = window_avg(sum_w[i]);
            end
            state_d = CMP0;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      cnt_q   <= '0;
      state_q <= ACCUM;
      max_q   <= '0;
      idx_q   <= '0;
      net_q   <= '0;
      wavg_q  <= '0;
      nw_q    <= 1'b1;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= acc_d[i];
        snap_q[i] <= snap_d[i];
      end
      cnt_q   <= cnt_d;
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      net_q   <= net_d;
      wavg_q  <= wavg_d;
      nw_q    <= nw_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.network_output = net_q;
  assign bus.winner_avg     = wavg_q;
  assign bus.no_winner      = nw_q;
  assign bus.result_valid   = rv_q;
  assign bus.sample_overrun = ovr_q;
endmodule
